// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N-channel arbitrating multiplexer.
package arb_mux_pkg;

   typedef enum logic {EMPTY, FULL} state_t;

   // Source index width, never narrower than one bit.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Round-robin arbiter with a fixed-priority bypass; the pointer advances
// on every transfer in both modes so round-robin resumes fairly.
module rr_arbiter_n
   import arb_mux_pkg::*;
#(
   parameter int N = 4,
   localparam int SW = src_width(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic          fixed_pri,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx
);

   localparam logic [SW:0] N_EXT = (SW+1)'(N);

   logic [SW-1:0]  ptr_reg;
   logic [SW-1:0]  ptr_next;
   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [SW-1:0]  rot_idx;
   logic [SW-1:0]  fix_idx;
   logic [SW:0]    idx_sum;
   logic           any_req;

   assign any_req = |req;
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr_reg +: N];

   always_comb begin
      rot_idx = '0;
      fix_idx = '0;
      // Descending scan: the last hit, i.e. the lowest index, wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) rot_idx = SW'(i);
         if (req[i])     fix_idx = SW'(i);
      end
      idx_sum = {1'b0, rot_idx} + {1'b0, ptr_reg};
      if (idx_sum >= N_EXT) idx_sum = idx_sum - N_EXT;
      grant_idx = fixed_pri ? fix_idx : idx_sum[SW-1:0];
      ptr_next  = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_grant
         assign grant[gi] = any_req && (grant_idx == SW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     ptr_reg <= '0;
      else if (advance) ptr_reg <= ptr_next;
   end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a one-entry registered output stage
// and valid/ready handshakes on every input and on the output.
module arb_mux_n
   import arb_mux_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int N = 4,
   localparam int SW = src_width(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               fixed_pri,
   output logic [WIDTH-1:0]   out_data,
   output logic [SW-1:0]      out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   state_t           state_reg;
   logic [WIDTH-1:0] data_reg;
   logic [SW-1:0]    src_reg;
   logic [N-1:0]     grant;
   logic [SW-1:0]    grant_idx;
   logic             load_en;
   logic             transfer;
   logic [WIDTH-1:0] word_sel;
   logic [WIDTH-1:0] word_masked [N];

   // The register can take a word when empty or when it is drained this cycle.
   assign load_en  = (state_reg == EMPTY) || out_ready;
   assign in_ready = grant & {N{load_en & reset_n}};
   assign transfer = |in_ready;

   rr_arbiter_n #(.N(N)) u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (in_valid),
      .fixed_pri (fixed_pri),
      .advance   (transfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_mask
         assign word_masked[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
      end
   endgenerate

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < N; i++) word_sel = word_sel | word_masked[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= EMPTY;
         data_reg  <= '0;
         src_reg   <= '0;
      end else if (transfer) begin
         state_reg <= FULL;
         data_reg  <= word_sel;
         src_reg   <= grant_idx;
      end else if (state_reg == FULL && out_ready) begin
         state_reg <= EMPTY;
      end
   end

   assign out_valid = (state_reg == FULL);
   assign out_data  = data_reg;
   assign out_src   = src_reg;

endmodule
